// File: rtl/vote_session_controller.sv
// vote_session_controller: runs one voter lookup/select/commit session at a time and keeps saturating candidate tallies
module vote_session_controller #(
  parameter int ID_W     = 4,
  parameter int NUM_CAND = 4,
  parameter int TALLY_W  = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        election_open,
  input  logic [ID_W-1:0]             voter_id,
  input  logic                        id_valid,
  input  logic                        voted_flag,
  input  logic [1:0]                  candidate_sel,
  input  logic                        confirm,
  input  logic                        cancel,
  output logic [ID_W-1:0]             mem_addr,
  output logic                        vote_cast,
  output logic                        busy,
  output logic                        accepted,
  output logic                        rejected,
  output logic                        timed_out,
  output logic [NUM_CAND*TALLY_W-1:0] tally,
  output logic [TALLY_W+1:0]          total_votes
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [2:0] {IDLE, LOOKUP, SELECT, COMMIT, REJECT, DONE} state_t;
  state_t                            r_state, w_next;
  logic [CW-1:0]                     r_cnt, w_cnt;
  logic [ID_W-1:0]                   r_mem_addr, w_mem_addr;
  logic                              r_vote_cast, r_busy, r_accepted, r_rejected, r_timed_out;
  logic                              w_vote_cast, w_busy, w_accepted, w_rejected, w_timeout;
  logic [NUM_CAND-1:0][TALLY_W-1:0]  r_tally;
  logic [TALLY_W+1:0]                r_total;
  logic                              w_bad_sel, w_open_id;
  assign w_bad_sel = 32'(candidate_sel) >= NUM_CAND;
  assign w_open_id = (r_state == IDLE) && id_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_vote_cast <= 1'b0;
      r_busy      <= 1'b0;
      r_accepted  <= 1'b0;
      r_rejected  <= 1'b0;
      r_timed_out <= 1'b0;
      r_tally     <= '0;
      r_total     <= '0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt;
      r_mem_addr  <= w_mem_addr;
      r_vote_cast <= w_vote_cast;
      r_busy      <= w_busy;
      r_accepted  <= w_accepted;
      r_rejected  <= w_rejected;
      r_timed_out <= w_timeout;
      if (w_vote_cast) begin
        r_total <= r_total + 1'b1;
        for (int c = 0; c < NUM_CAND; c++)
          if (c == 32'(candidate_sel) && r_tally[c] != '1) r_tally[c] <= r_tally[c] + 1'b1;
      end
    end
  end
  always_comb begin
    w_next    = r_state;
    w_cnt     = r_cnt;
    w_timeout = 1'b0;
    case (r_state)
      IDLE:   w_next = (id_valid && election_open) ? LOOKUP : IDLE;
      LOOKUP: begin
        w_next = voted_flag ? REJECT : SELECT;
        w_cnt  = '0;
      end
      SELECT: begin
        if (cancel || !election_open || (confirm && w_bad_sel)) w_next = IDLE;
        else if (confirm) w_next = COMMIT;
        else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_next    = IDLE;
          w_timeout = 1'b1;
        end else w_cnt = r_cnt + 1'b1;
      end
      COMMIT: w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_mem_addr  = (w_open_id && election_open) ? voter_id : r_mem_addr;
    w_vote_cast = w_next == COMMIT;
    w_accepted  = w_next == COMMIT;
    w_rejected  = (w_next == REJECT) || (w_open_id && !election_open);
    w_busy      = w_next != IDLE;
  end
  assign mem_addr    = r_mem_addr;
  assign vote_cast   = r_vote_cast;
  assign busy        = r_busy;
  assign accepted    = r_accepted;
  assign rejected    = r_rejected;
  assign timed_out   = r_timed_out;
  assign tally       = r_tally;
  assign total_votes = r_total;
endmodule

// File: tb/tb_vote_session_controller.sv
// tb_vote_session_controller: directed checks of session flow, rejects, timeout, aborts and tally saturation
module tb_vote_session_controller;
  logic        clk = 1'b0, rst = 1'b1, election_open = 1'b0, id_valid = 1'b0, voted_flag = 1'b0;
  logic        confirm = 1'b0, cancel = 1'b0;
  logic [3:0]  voter_id = '0, mem_addr;
  logic [1:0]  candidate_sel = '0;
  logic        vote_cast, busy, accepted, rejected, timed_out;
  logic [31:0] tally;
  logic [9:0]  total_votes;
  int          n_cmp = 0, n_bad = 0, n_cast = 0, n_acc = 0, base_cast, base_acc;
  logic [3:0]  cast_addr = '0;
  vote_session_controller #(.ID_W(4), .NUM_CAND(4), .TALLY_W(8), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .election_open(election_open), .voter_id(voter_id), .id_valid(id_valid),
    .voted_flag(voted_flag), .candidate_sel(candidate_sel), .confirm(confirm), .cancel(cancel),
    .mem_addr(mem_addr), .vote_cast(vote_cast), .busy(busy), .accepted(accepted), .rejected(rejected),
    .timed_out(timed_out), .tally(tally), .total_votes(total_votes)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (vote_cast) begin
      n_cast++;
      cast_addr = mem_addr;
    end
    if (accepted) n_acc++;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic enter_select(input logic [3:0] id);
    voter_id = id;
    id_valid = 1'b1;
    step();
    id_valid   = 1'b0;
    voted_flag = 1'b0;
    step();
  endtask
  initial begin
    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_tally", tally, 0);
    chk("rst_total", 32'(total_votes), 0);
    rst = 1'b0;
    election_open = 1'b1;
    voter_id = 4'd5;
    id_valid = 1'b1;
    step();
    id_valid = 1'b0;
    chk("lookup_busy", 32'(busy), 1);
    chk("lookup_addr", 32'(mem_addr), 5);
    step();
    confirm = 1'b1;
    candidate_sel = 2'd2;
    step();
    confirm = 1'b0;
    chk("commit_cast", 32'(vote_cast), 1);
    chk("commit_acc", 32'(accepted), 1);
    chk("commit_tally", tally, 32'h0001_0000);
    chk("commit_total", 32'(total_votes), 1);
    step();
    chk("done_cast", 32'(vote_cast), 0);
    chk("done_busy", 32'(busy), 1);
    step();
    chk("v5_idle", 32'(busy), 0);
    chk("v5_ncast", 32'(n_cast), 1);
    chk("v5_castaddr", 32'(cast_addr), 5);
    id_valid = 1'b1;
    step();
    id_valid = 1'b0;
    voted_flag = 1'b1;
    step();
    voted_flag = 1'b0;
    chk("rep_rej", 32'(rejected), 1);
    step();
    chk("rep_rej_end", 32'(rejected), 0);
    chk("rep_busy", 32'(busy), 0);
    chk("rep_tally", tally, 32'h0001_0000);
    chk("rep_ncast", 32'(n_cast), 1);
    enter_select(4'd3);
    for (int i = 0; i < 7; i++) step();
    chk("to_wait_busy", 32'(busy), 1);
    chk("to_wait_flag", 32'(timed_out), 0);
    step();
    chk("to_flag", 32'(timed_out), 1);
    chk("to_busy", 32'(busy), 0);
    step();
    chk("to_flag_end", 32'(timed_out), 0);
    chk("to_ncast", 32'(n_cast), 1);
    enter_select(4'd6);
    confirm = 1'b1;
    cancel = 1'b1;
    step();
    confirm = 1'b0;
    cancel = 1'b0;
    chk("cc_busy", 32'(busy), 0);
    chk("cc_acc", 32'(accepted), 0);
    step();
    chk("cc_ncast", 32'(n_cast), 1);
    election_open = 1'b0;
    voter_id = 4'd7;
    id_valid = 1'b1;
    step();
    id_valid = 1'b0;
    chk("closed_rej", 32'(rejected), 1);
    chk("closed_busy", 32'(busy), 0);
    chk("closed_addr", 32'(mem_addr), 6);
    step();
    chk("closed_rej_end", 32'(rejected), 0);
    election_open = 1'b1;
    enter_select(4'd8);
    election_open = 1'b0;
    step();
    election_open = 1'b1;
    chk("drop_busy", 32'(busy), 0);
    confirm = 1'b1;
    step();
    confirm = 1'b0;
    step();
    chk("drop_ncast", 32'(n_cast), 1);
    chk("drop_total", 32'(total_votes), 1);
    enter_select(4'd9);
    chk("rst_mid_addr_pre", 32'(mem_addr), 9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_addr", 32'(mem_addr), 0);
    chk("rst_mid_tally", tally, 0);
    chk("rst_mid_total", 32'(total_votes), 0);
    step();
    chk("rst_mid_ncast", 32'(n_cast), 1);
    base_cast = n_cast;
    base_acc = n_acc;
    candidate_sel = 2'd0;
    for (int v = 0; v < 257; v++) begin
      enter_select(4'(v));
      confirm = 1'b1;
      step();
      confirm = 1'b0;
      step();
      step();
    end
    chk("sat_tally0", 32'(tally[7:0]), 255);
    chk("sat_others", 32'(tally[31:8]), 0);
    chk("sat_total", 32'(total_votes), 257);
    chk("sat_ncast", 32'(n_cast - base_cast), 257);
    chk("sat_nacc", 32'(n_acc - base_acc), 257);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
